// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, instruction
// classes, opcode/funct/alu_op constants, error codes and the registered control bundle.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_RTYPE  = 4'd7,
        S_ALUWB  = 4'd8,
        S_IMMEX  = 4'd9,
        S_BRANCH = 4'd10,
        S_ERROR  = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        K_RTYPE = 3'd0,
        K_LW    = 3'd1,
        K_SW    = 3'd2,
        K_ADDI  = 3'd3,
        K_ORI   = 3'd4,
        K_BEQ   = 3'd5,
        K_BAD   = 3'd6
    } kind_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_OPCODE  = 2'b01;
    localparam logic [1:0] ERR_FUNCT   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef struct packed {
        logic       pc_write_cond;
        logic       pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       imm_extend;
        logic       retire;
        logic       error;
    } ctrl_t;

endpackage

// File: rtl/instr_classifier.sv
// Combinational decode of opcode into an instruction class and of funct
// into an R-type ALU operation with a validity flag.
module instr_classifier
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] kind,
    output logic       funct_ok,
    output logic [2:0] funct_alu_op
);

    // Opcode class and funct mapping; unknown encodings fall through to the invalid case
    always_comb begin
        case (opcode)
            OP_RTYPE: kind = K_RTYPE;
            OP_LW:    kind = K_LW;
            OP_SW:    kind = K_SW;
            OP_ADDI:  kind = K_ADDI;
            OP_ORI:   kind = K_ORI;
            OP_BEQ:   kind = K_BEQ;
            default:  kind = K_BAD;
        endcase

        funct_ok = 1'b1;
        case (funct)
            FN_ADD:  funct_alu_op = ALU_ADD;
            FN_SUB:  funct_alu_op = ALU_SUB;
            FN_SLT:  funct_alu_op = ALU_SLT;
            FN_AND:  funct_alu_op = ALU_AND;
            FN_OR:   funct_alu_op = ALU_OR;
            default: begin
                funct_ok     = 1'b0;
                funct_alu_op = 3'b000;
            end
        endcase
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS-subset control FSM. Moore controls are registered from the
// next state; the memory-completion enables are gated by mem_ready in the same cycle.
module multi_cycle_controller
    import ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             pc_src,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             imm_extend,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count,
    output logic             error,
    output logic [1:0]       error_code
);

    localparam int WW = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_LIMIT - 1);

    state_t           state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [2:0]       kind_q, kind_d;
    logic             funct_ok_q, funct_ok_d;
    logic [2:0]       falu_q, falu_d;
    logic [1:0]       err_code_q, err_code_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [2:0] kind_s;
    logic       funct_ok_s;
    logic [2:0] falu_s;
    logic       mem_wait_s;
    logic       timeout_s;
    logic       retire_s;
    logic       unused_zero_s;

    // zero is consumed by the datapath together with pc_write_cond
    assign unused_zero_s = zero;

    instr_classifier u_classifier (
        .opcode       (opcode),
        .funct        (funct),
        .kind         (kind_s),
        .funct_ok     (funct_ok_s),
        .funct_alu_op (falu_s)
    );

    assign mem_wait_s = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign timeout_s  = mem_wait_s && !mem_ready && (wait_q == WAIT_LAST);
    assign retire_s   = ctrl_q.retire | ((state_q == S_MEMWR) & mem_ready);
    assign count_d    = count_q + CNT_W'(retire_s);

    // Instruction capture in DECODE, next-state selection and the memory wait counter
    always_comb begin
        if (state_q == S_DECODE) begin
            kind_d     = kind_s;
            funct_ok_d = funct_ok_s;
            falu_d     = falu_s;
        end else begin
            kind_d     = kind_q;
            funct_ok_d = funct_ok_q;
            falu_d     = falu_q;
        end

        state_d    = state_q;
        err_code_d = err_code_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout_s) begin
                    state_d    = S_ERROR;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                case (kind_d)
                    K_RTYPE:      state_d = S_RTYPE;
                    K_LW, K_SW:   state_d = S_MEMADR;
                    K_ADDI, K_ORI: state_d = S_IMMEX;
                    K_BEQ:        state_d = S_BRANCH;
                    default: begin
                        state_d    = S_ERROR;
                        err_code_d = ERR_OPCODE;
                    end
                endcase
            end
            S_RTYPE: begin
                if (funct_ok_q) begin
                    state_d = S_ALUWB;
                end else begin
                    state_d    = S_ERROR;
                    err_code_d = ERR_FUNCT;
                end
            end
            S_IMMEX:  state_d = S_ALUWB;
            S_MEMADR: state_d = (kind_q == K_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD, S_MEMWR: begin
                if (mem_ready) begin
                    state_d = (state_q == S_MEMRD) ? S_MEMWB : S_FETCH;
                end else if (timeout_s) begin
                    state_d    = S_ERROR;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    state_d = state_q;
                end
            end
            S_ALUWB, S_MEMWB, S_BRANCH: state_d = S_FETCH;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_ERROR;
        endcase

        if (state_d != state_q) begin
            wait_d = {WW{1'b0}};
        end else if (mem_wait_s && !mem_ready) begin
            wait_d = wait_q + WW'(1'b1);
        end else begin
            wait_d = wait_q;
        end
    end

    // Moore control word for the state being entered, registered one cycle ahead
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_FETCH: begin
                ctrl_d.mem_read  = 1'b1;
                ctrl_d.alu_src_b = 2'b01;
                ctrl_d.alu_op    = ALU_ADD;
            end
            S_DECODE: begin
                ctrl_d.alu_src_b = 2'b11;
                ctrl_d.alu_op    = ALU_ADD;
            end
            S_RTYPE: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_op    = falu_d;
            end
            S_ALUWB: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.reg_dst   = (state_q == S_RTYPE);
                ctrl_d.retire    = 1'b1;
            end
            S_IMMEX: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = 2'b10;
                if (kind_d == K_ORI) begin
                    ctrl_d.alu_op     = ALU_OR;
                    ctrl_d.imm_extend = 1'b1;
                end else begin
                    ctrl_d.alu_op     = ALU_ADD;
                    ctrl_d.imm_extend = 1'b0;
                end
            end
            S_MEMADR: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = 2'b10;
                ctrl_d.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl_d.mem_read = 1'b1;
                ctrl_d.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.retire     = 1'b1;
            end
            S_MEMWR: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.i_or_d    = 1'b1;
            end
            S_BRANCH: begin
                ctrl_d.alu_src_a     = 1'b1;
                ctrl_d.alu_op        = ALU_SUB;
                ctrl_d.pc_write_cond = 1'b1;
                ctrl_d.pc_src        = 1'b1;
                ctrl_d.retire        = 1'b1;
            end
            S_ERROR:  ctrl_d.error = 1'b1;
            default:  ctrl_d = '0;
        endcase
    end

    // State, captured instruction, counters and registered controls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wait_q     <= {WW{1'b0}};
            kind_q     <= K_BAD;
            funct_ok_q <= 1'b0;
            falu_q     <= 3'b000;
            err_code_q <= ERR_NONE;
            ctrl_q     <= '0;
            count_q    <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            kind_q     <= kind_d;
            funct_ok_q <= funct_ok_d;
            falu_q     <= falu_d;
            err_code_q <= err_code_d;
            ctrl_q     <= ctrl_d;
            count_q    <= count_d;
        end
    end

    assign pc_write      = (state_q == S_FETCH) & mem_ready;
    assign ir_write      = (state_q == S_FETCH) & mem_ready;
    assign pc_write_cond = ctrl_q.pc_write_cond;
    assign pc_src        = ctrl_q.pc_src;
    assign i_or_d        = ctrl_q.i_or_d;
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign reg_write     = ctrl_q.reg_write;
    assign reg_dst       = ctrl_q.reg_dst;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign alu_op        = ctrl_q.alu_op;
    assign imm_extend    = ctrl_q.imm_extend;
    assign retire        = retire_s;
    assign instr_count   = count_q;
    assign error         = ctrl_q.error;
    assign error_code    = err_code_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Self-checking bench: a table of single-instruction runs, directed corner
// sequences, and randomized instruction streams against a phase-level model.
module tb_multi_cycle_controller;

    localparam int WL = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [5:0]    opcode = 6'h00;
    logic [5:0]    funct = 6'h20;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write;
    logic          ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]    alu_src_b;
    logic [2:0]    alu_op;
    logic          imm_extend, retire, error;
    logic [CW-1:0] instr_count;
    logic [1:0]    error_code;

    always #5 clk = ~clk;

    multi_cycle_controller #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_src(pc_src), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .imm_extend(imm_extend), .retire(retire),
        .instr_count(instr_count), .error(error), .error_code(error_code)
    );

    typedef struct packed {
        logic       pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write;
        logic       ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       imm_extend, retire, error;
        logic [1:0] error_code;
    } cw_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         ret_cyc;
        logic [2:0] alu3;
        logic [1:0] ecode;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int model_cnt = 0;

    function automatic cw_t actual();
        cw_t a;
        a.pc_write = pc_write;   a.pc_write_cond = pc_write_cond; a.pc_src = pc_src;
        a.i_or_d = i_or_d;       a.mem_read = mem_read;           a.mem_write = mem_write;
        a.ir_write = ir_write;   a.reg_write = reg_write;         a.reg_dst = reg_dst;
        a.mem_to_reg = mem_to_reg; a.alu_src_a = alu_src_a;       a.alu_src_b = alu_src_b;
        a.alu_op = alu_op;       a.imm_extend = imm_extend;       a.retire = retire;
        a.error = error;         a.error_code = error_code;
        return a;
    endfunction

    function automatic logic rnd();
        return 1'($urandom);
    endfunction

    function automatic logic [2:0] ref_alu(input logic [5:0] f);
        case (f)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h2A:   return 3'b111;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit funct_valid(input logic [5:0] f);
        return (f == 6'h20) || (f == 6'h22) || (f == 6'h2A) || (f == 6'h24) || (f == 6'h25);
    endfunction

    // Expected control words per phase, taken from the phase descriptions
    function automatic cw_t c_fetch(input logic mr);
        cw_t c = '0;
        c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.alu_op = 3'b010;
        c.ir_write = mr;   c.pc_write = mr;
        return c;
    endfunction
    function automatic cw_t c_decode();
        cw_t c = '0;
        c.alu_src_b = 2'b11; c.alu_op = 3'b010;
        return c;
    endfunction
    function automatic cw_t c_rtype(input logic [5:0] f);
        cw_t c = '0;
        c.alu_src_a = 1'b1; c.alu_op = ref_alu(f);
        return c;
    endfunction
    function automatic cw_t c_aluwb(input logic dst);
        cw_t c = '0;
        c.reg_write = 1'b1; c.reg_dst = dst; c.retire = 1'b1;
        return c;
    endfunction
    function automatic cw_t c_immex(input logic is_ori);
        cw_t c = '0;
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        c.alu_op = is_ori ? 3'b001 : 3'b010; c.imm_extend = is_ori;
        return c;
    endfunction
    function automatic cw_t c_memadr();
        cw_t c = '0;
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 3'b010;
        return c;
    endfunction
    function automatic cw_t c_memwb();
        cw_t c = '0;
        c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.retire = 1'b1;
        return c;
    endfunction
    function automatic cw_t c_branch();
        cw_t c = '0;
        c.alu_src_a = 1'b1; c.alu_op = 3'b110; c.pc_write_cond = 1'b1;
        c.pc_src = 1'b1; c.retire = 1'b1;
        return c;
    endfunction
    function automatic cw_t c_err(input logic [1:0] code);
        cw_t c = '0;
        c.error = 1'b1; c.error_code = code;
        return c;
    endfunction
    // kind: 0 = instruction fetch, 1 = data read, 2 = data write
    function automatic cw_t c_wait(input int kind, input logic mr);
        cw_t c = '0;
        if (kind == 0) begin
            c = c_fetch(mr);
        end else begin
            c.i_or_d = 1'b1;
            c.mem_read = (kind == 1);
            c.mem_write = (kind == 2);
            c.retire = (kind == 2) && mr;
        end
        return c;
    endfunction

    task automatic check_cw(input string nm, input cw_t exp);
        cw_t a;
        a = actual();
        checks++;
        if (a !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", nm, a, exp);
        end
    endtask

    task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    task automatic step(input logic mr, input cw_t exp, input string nm);
        @(negedge clk);
        mem_ready = mr;
        zero = rnd();
        #1;
        check_cw(nm, exp);
        check_val({nm, "/count"}, 32'(instr_count), 32'(model_cnt % (1 << CW)));
        if (exp.retire) model_cnt++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        model_cnt = 0;
        check_cw("reset", '0);
        check_val("reset/count", 32'(instr_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_cw("idle", '0);
    endtask

    // n cycles with mem_ready low, then one high; WL low cycles is a timeout
    task automatic mem_wait(input int kind, input int n, output bit to);
        to = 1'b0;
        for (int i = 0; i < WL; i++) begin
            if (i >= n) begin
                step(1'b1, c_wait(kind, 1'b1), "wait_done");
                return;
            end
            step(1'b0, c_wait(kind, 1'b0), "wait");
        end
        to = 1'b1;
    endtask

    task automatic err_cycles(input logic [1:0] code, input int n);
        for (int i = 0; i < n; i++) step(rnd(), c_err(code), "error");
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                             input int mw, input int ecyc, output bit err);
        bit to;
        err = 1'b0;
        opcode = op;
        funct = fn;
        mem_wait(0, fw, to);
        if (to) begin
            err_cycles(2'b11, ecyc);
            err = 1'b1;
            return;
        end
        step(rnd(), c_decode(), "decode");
        case (op)
            6'h00: begin
                step(rnd(), c_rtype(fn), "rtype");
                if (funct_valid(fn)) begin
                    step(rnd(), c_aluwb(1'b1), "aluwb_r");
                end else begin
                    err_cycles(2'b10, ecyc);
                    err = 1'b1;
                end
            end
            6'h23, 6'h2B: begin
                step(rnd(), c_memadr(), "memadr");
                mem_wait((op == 6'h23) ? 1 : 2, mw, to);
                if (to) begin
                    err_cycles(2'b11, ecyc);
                    err = 1'b1;
                end else if (op == 6'h23) begin
                    step(rnd(), c_memwb(), "memwb");
                end
            end
            6'h08, 6'h0D: begin
                step(rnd(), c_immex(op == 6'h0D), "immex");
                step(rnd(), c_aluwb(1'b0), "aluwb_i");
            end
            6'h04: step(rnd(), c_branch(), "branch");
            default: begin
                err_cycles(2'b01, ecyc);
                err = 1'b1;
            end
        endcase
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t tbl[12];
        logic [5:0] ops[6];
        logic [5:0] fns[5];
        bit err;
        int rc;
        logic [2:0] a3;

        tbl[0]  = '{6'h00, 6'h20, 4, 3'b010, 2'b00};
        tbl[1]  = '{6'h00, 6'h22, 4, 3'b110, 2'b00};
        tbl[2]  = '{6'h00, 6'h2A, 4, 3'b111, 2'b00};
        tbl[3]  = '{6'h00, 6'h24, 4, 3'b000, 2'b00};
        tbl[4]  = '{6'h00, 6'h25, 4, 3'b001, 2'b00};
        tbl[5]  = '{6'h00, 6'h3F, 0, 3'b000, 2'b10};
        tbl[6]  = '{6'h23, 6'h00, 5, 3'b010, 2'b00};
        tbl[7]  = '{6'h2B, 6'h00, 4, 3'b010, 2'b00};
        tbl[8]  = '{6'h08, 6'h00, 4, 3'b010, 2'b00};
        tbl[9]  = '{6'h0D, 6'h00, 4, 3'b001, 2'b00};
        tbl[10] = '{6'h04, 6'h00, 3, 3'b110, 2'b00};
        tbl[11] = '{6'h3F, 6'h20, 0, 3'b000, 2'b01};
        ops = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h0D, 6'h04};
        fns = '{6'h20, 6'h22, 6'h2A, 6'h24, 6'h25};

        // Single instructions with memory always ready; cycle 1 is the first FETCH
        for (int r = 0; r < 12; r++) begin
            do_reset();
            opcode = tbl[r].op;
            funct = tbl[r].fn;
            mem_ready = 1'b1;
            rc = 0;
            a3 = 3'b000;
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                #1;
                if (retire === 1'b1 && rc == 0) rc = c;
                if (c == 3) a3 = alu_op;
            end
            check_val($sformatf("tbl%0d_retire_cycle", r), rc, tbl[r].ret_cyc);
            check_val($sformatf("tbl%0d_alu_op_c3", r), 32'(a3), 32'(tbl[r].alu3));
            check_val($sformatf("tbl%0d_error_code", r), 32'(error_code), 32'(tbl[r].ecode));
        end

        do_reset();
        run_instr(6'h00, 6'h20, 0, 0, 2, err);
        run_instr(6'h23, 6'h00, 0, 3, 2, err);
        run_instr(6'h0D, 6'h00, 1, 0, 2, err);
        run_instr(6'h2B, 6'h00, 2, 3, 2, err);
        run_instr(6'h3F, 6'h20, 0, 0, 10, err);
        do_reset();

        run_instr(6'h00, 6'h20, WL, 0, 3, err);
        do_reset();
        run_instr(6'h00, 6'h20, WL - 1, 0, 3, err);
        run_instr(6'h23, 6'h00, 0, WL, 3, err);
        do_reset();

        // Reset in the middle of a data-read wait must not retire
        opcode = 6'h23;
        step(1'b1, c_fetch(1'b1), "abort_fetch");
        step(1'b0, c_decode(), "abort_decode");
        step(1'b0, c_memadr(), "abort_memadr");
        step(1'b0, c_wait(1, 1'b0), "abort_wait0");
        step(1'b0, c_wait(1, 1'b0), "abort_wait1");
        do_reset();

        for (int i = 0; i < 17; i++) run_instr(6'h04, 6'h00, 0, 0, 0, err);
        @(negedge clk);
        #1;
        check_val("beq_wrap_count", 32'(instr_count), 32'd1);
        do_reset();

        for (int n = 0; n < 200; n++) begin
            logic [5:0] op, fn;
            int fw, mw;
            op = ($urandom_range(0, 7) < 6) ? ops[$urandom_range(0, 5)] : 6'($urandom);
            fn = ($urandom_range(0, 4) != 0) ? fns[$urandom_range(0, 4)] : 6'($urandom);
            fw = ($urandom_range(0, 9) == 0) ? WL : $urandom_range(0, WL - 1);
            mw = ($urandom_range(0, 9) == 0) ? WL : $urandom_range(0, WL - 1);
            run_instr(op, fn, fw, mw, 2, err);
            if (err) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
